// File: rtl/systimer_host_if.sv
// ---------------------------------------------------------------------------
// systimer_host_if
// Avalon-MM connection between systimer_host (master) and the 16-bit
// interval-timer s1 port (slave), including the timer's interrupt line.
//   avm_address    [2:0]  timer register index
//   avm_chipselect        slave select
//   avm_write_n           active-low write strobe
//   avm_writedata  [15:0] write data
//   avm_readdata   [15:0] read data, valid one cycle after the address
//   timer_irq             level interrupt from the timer
// ---------------------------------------------------------------------------
interface systimer_host_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        timer_irq;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, timer_irq
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, timer_irq
    );
endinterface

// File: rtl/systimer_host.sv
// ---------------------------------------------------------------------------
// systimer_host
// Avalon-MM initiator for the 6-register interval timer of the PCM player.
// Programs the period and starts the timer, stops it, acknowledges its
// interrupt (turning each one into a single-cycle tick), and reads counter
// snapshots.
//   clk, reset_n          clock, asynchronous active-low reset
//   avm (master)          timer bus plus timer_irq
//   i_start_req           pulse: program period and start timer
//   i_stop_req            pulse: stop timer
//   i_snap_req            pulse: capture and read counter snapshot
//   i_cfg_period   [31:0] load value, sampled when start is accepted
//   i_cfg_continuous      1 = periodic, 0 = one-shot
//   o_busy                sequencer not in IDLE
//   o_timer_running       host's view of the timer run state
//   o_tick                one-cycle pulse per serviced interrupt
//   o_tick_count   [TICK_W-1:0] serviced-interrupt count (wraps)
//   o_snap_value   [31:0] last snapshot {high, low}
//   o_snap_valid          one-cycle pulse when o_snap_value updates
// ---------------------------------------------------------------------------
module systimer_host #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    systimer_host_if.master   avm,
    input  logic              i_start_req,
    input  logic              i_stop_req,
    input  logic              i_snap_req,
    input  logic [31:0]       i_cfg_period,
    input  logic              i_cfg_continuous,
    output logic              o_busy,
    output logic              o_timer_running,
    output logic              o_tick,
    output logic [TICK_W-1:0] o_tick_count,
    output logic [31:0]       o_snap_value,
    output logic              o_snap_valid
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_WR_STOP,
        S_ACK, S_SNAP_WR, S_RD_L, S_RD_H, S_RD_DONE
    } state_t;

    state_t              r_state;
    logic                r_start_pend, r_stop_pend, r_snap_pend;
    logic [15:0]         r_period_hi;
    logic                r_cont;
    logic [2:0]          r_address;
    logic                r_chipselect, r_write_n;
    logic [15:0]         r_writedata;
    logic                r_busy, r_running, r_tick, r_snap_valid;
    logic [TICK_W-1:0]   r_tick_count;
    logic [15:0]         r_snap_lo;
    logic [31:0]         r_snap_value;

    // A request arriving in the same cycle IDLE arbitrates is seen at once.
    logic w_start_pend, w_stop_pend, w_snap_pend;
    assign w_start_pend = r_start_pend | i_start_req;
    assign w_stop_pend  = r_stop_pend  | i_stop_req;
    assign w_snap_pend  = r_snap_pend  | i_snap_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_start_pend <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_snap_pend  <= 1'b0;
            r_period_hi  <= 16'h0000;
            r_cont       <= 1'b0;
            r_address    <= 3'd0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= 16'h0000;
            r_busy       <= 1'b0;
            r_running    <= 1'b0;
            r_tick       <= 1'b0;
            r_snap_valid <= 1'b0;
            r_tick_count <= '0;
            r_snap_lo    <= 16'h0000;
            r_snap_value <= 32'h0000_0000;
        end else begin
            r_tick       <= 1'b0;
            r_snap_valid <= 1'b0;
            r_start_pend <= w_start_pend;
            r_stop_pend  <= w_stop_pend;
            r_snap_pend  <= w_snap_pend;

            case (r_state)
                S_IDLE: begin
                    if (w_stop_pend) begin
                        r_stop_pend  <= 1'b0;
                        r_state      <= S_WR_STOP;
                        r_busy       <= 1'b1;
                        r_running    <= 1'b0;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_address    <= 3'd1;
                        r_writedata  <= 16'h0008;
                    end else if (w_start_pend) begin
                        r_start_pend <= 1'b0;
                        r_state      <= S_WR_PL;
                        r_busy       <= 1'b1;
                        r_period_hi  <= i_cfg_period[31:16];
                        r_cont       <= i_cfg_continuous;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_address    <= 3'd2;
                        r_writedata  <= i_cfg_period[15:0];
                    end else if (avm.timer_irq) begin
                        // Tick and count move on the edge the ACK write is issued.
                        r_state      <= S_ACK;
                        r_busy       <= 1'b1;
                        r_tick       <= 1'b1;
                        r_tick_count <= r_tick_count + TICK_W'(1);
                        if (!r_cont)
                            r_running <= 1'b0;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_address    <= 3'd0;
                        r_writedata  <= 16'h0000;
                    end else if (w_snap_pend) begin
                        r_snap_pend  <= 1'b0;
                        r_state      <= S_SNAP_WR;
                        r_busy       <= 1'b1;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_address    <= 3'd4;
                        r_writedata  <= 16'h0000;
                    end
                end
                S_WR_PL: begin
                    r_state     <= S_WR_PH;
                    r_address   <= 3'd3;
                    r_writedata <= r_period_hi;
                end
                S_WR_PH: begin
                    // Control: stop=0, start=1, cont, ito=1.
                    r_state     <= S_WR_CTL;
                    r_running   <= 1'b1;
                    r_address   <= 3'd1;
                    r_writedata <= {12'h000, 1'b0, 1'b1, r_cont, 1'b1};
                end
                S_WR_CTL, S_WR_STOP, S_ACK: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_chipselect <= 1'b0;
                    r_write_n    <= 1'b1;
                end
                S_SNAP_WR: begin
                    r_state   <= S_RD_L;
                    r_write_n <= 1'b1;
                    r_address <= 3'd4;
                end
                S_RD_L: begin
                    r_state   <= S_RD_H;
                    r_address <= 3'd5;
                end
                S_RD_H: begin
                    // Readdata now carries the low half requested in RD_L.
                    r_state      <= S_RD_DONE;
                    r_snap_lo    <= avm.avm_readdata;
                    r_chipselect <= 1'b0;
                    r_write_n    <= 1'b1;
                end
                S_RD_DONE: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_snap_value <= {avm.avm_readdata, r_snap_lo};
                    r_snap_valid <= 1'b1;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_chipselect <= 1'b0;
                    r_write_n    <= 1'b1;
                end
            endcase
        end
    end

    assign avm.avm_address    = r_address;
    assign avm.avm_chipselect = r_chipselect;
    assign avm.avm_write_n    = r_write_n;
    assign avm.avm_writedata  = r_writedata;

    assign o_busy          = r_busy;
    assign o_timer_running = r_running;
    assign o_tick          = r_tick;
    assign o_tick_count    = r_tick_count;
    assign o_snap_value    = r_snap_value;
    assign o_snap_valid    = r_snap_valid;

endmodule

// File: tb/tb_systimer_host.sv
module tb_systimer_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        start_req = 1'b0, stop_req = 1'b0, snap_req = 1'b0;
    logic [31:0] cfg_period = 32'h0;
    logic        cfg_cont = 1'b0;
    logic        busy, running, tick, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;

    logic        start2 = 1'b0, stop2 = 1'b0, snap2 = 1'b0;
    logic        busy2, running2, tick2, snap_valid2;
    logic [3:0]  tick_count2;
    logic [31:0] snap_value2;

    systimer_host_if bus1();
    systimer_host_if bus2();

    systimer_host #(.TICK_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .avm(bus1),
        .i_start_req(start_req), .i_stop_req(stop_req), .i_snap_req(snap_req),
        .i_cfg_period(cfg_period), .i_cfg_continuous(cfg_cont),
        .o_busy(busy), .o_timer_running(running), .o_tick(tick),
        .o_tick_count(tick_count), .o_snap_value(snap_value), .o_snap_valid(snap_valid)
    );

    systimer_host #(.TICK_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .avm(bus2),
        .i_start_req(start2), .i_stop_req(stop2), .i_snap_req(snap2),
        .i_cfg_period(cfg_period), .i_cfg_continuous(cfg_cont),
        .o_busy(busy2), .o_timer_running(running2), .o_tick(tick2),
        .o_tick_count(tick_count2), .o_snap_value(snap_value2), .o_snap_valid(snap_valid2)
    );

    // ---------------- interval-timer slave model ----------------
    logic [15:0] m_pl = 16'h0, m_ph = 16'h0, m_rd = 16'h0;
    logic        m_ito = 1'b0, m_cont = 1'b0, m_run = 1'b0, m_to = 1'b0;
    logic [31:0] m_cnt = 32'h0, m_snap = 32'h0;
    logic        set_to = 1'b0, clr_to = 1'b0, force_cnt = 1'b0;
    logic [31:0] force_val = 32'h0;

    always @(posedge clk) begin
        if (m_run) begin
            if (m_cnt == 32'h0) begin
                m_to  <= 1'b1;
                m_cnt <= {m_ph, m_pl};
                if (!m_cont) m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 32'h1;
            end
        end
        if (force_cnt) m_cnt <= force_val;
        if (set_to)    m_to  <= 1'b1;
        if (clr_to)    m_to  <= 1'b0;
        if (bus1.avm_chipselect && !bus1.avm_write_n) begin
            case (bus1.avm_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito  <= bus1.avm_writedata[0];
                    m_cont <= bus1.avm_writedata[1];
                    if (bus1.avm_writedata[2]) begin
                        m_run <= 1'b1;
                        m_cnt <= {m_ph, m_pl};
                    end
                    if (bus1.avm_writedata[3]) m_run <= 1'b0;
                end
                3'd2: m_pl <= bus1.avm_writedata;
                3'd3: m_ph <= bus1.avm_writedata;
                3'd4: m_snap <= m_cnt;
                default: ;
            endcase
        end
        if (bus1.avm_chipselect && bus1.avm_write_n) begin
            case (bus1.avm_address)
                3'd0: m_rd <= {14'h0, m_run, m_to};
                3'd1: m_rd <= {12'h0, 1'b0, 1'b0, m_cont, m_ito};
                3'd2: m_rd <= m_pl;
                3'd3: m_rd <= m_ph;
                3'd4: m_rd <= m_snap[15:0];
                3'd5: m_rd <= m_snap[31:16];
                default: m_rd <= 16'h0;
            endcase
        end
    end
    assign bus1.avm_readdata = m_rd;
    assign bus1.timer_irq    = m_to & m_ito;

    // Minimal slave for the 4-bit-counter instance: irq set by bench, cleared by ACK.
    logic irq2 = 1'b0, set_irq2 = 1'b0;
    always @(posedge clk) begin
        if (set_irq2) irq2 <= 1'b1;
        if (bus2.avm_chipselect && !bus2.avm_write_n && bus2.avm_address == 3'd0) irq2 <= 1'b0;
    end
    assign bus2.avm_readdata = 16'h0000;
    assign bus2.timer_irq    = irq2;

    // ---------------- bus monitor ----------------
    logic [18:0] wlog[$];
    logic [2:0]  rlog[$];
    int tick_seen = 0, tick2_seen = 0, to_events = 0;

    always @(posedge clk) begin
        if (bus1.avm_chipselect && !bus1.avm_write_n) wlog.push_back({bus1.avm_address, bus1.avm_writedata});
        if (bus1.avm_chipselect && bus1.avm_write_n)  rlog.push_back(bus1.avm_address);
        if (tick)  tick_seen  <= tick_seen + 1;
        if (tick2) tick2_seen <= tick2_seen + 1;
        if (m_run && m_cnt == 32'h0) to_events <= to_events + 1;
    end

    int checks = 0, errors = 0;

    task automatic test_reset;
        $display("test_reset");
        checks++; if (bus1.avm_chipselect !== 1'b0 || bus1.avm_write_n !== 1'b1 || bus1.avm_address !== 3'd0 || bus1.avm_writedata !== 16'h0) begin
            errors++; $display("FAIL reset_bus: got cs=%b wn=%b addr=%0d data=%h, expected 0 1 0 0000", bus1.avm_chipselect, bus1.avm_write_n, bus1.avm_address, bus1.avm_writedata); end
        checks++; if (busy !== 1'b0 || running !== 1'b0 || tick !== 1'b0 || snap_valid !== 1'b0 || tick_count !== 16'h0 || snap_value !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: got busy=%b run=%b tick=%b sv=%b tc=%h snap=%h, expected all 0", busy, running, tick, snap_valid, tick_count, snap_value); end
    endtask

    task automatic test_start;
        logic [2:0]  ea[3] = '{3'd2, 3'd3, 3'd1};
        logic [15:0] ed[3] = '{16'h86A0, 16'h0001, 16'h0007};
        $display("test_start: period=000186a0 cont=1");
        @(negedge clk); cfg_period = 32'h0001_86A0; cfg_cont = 1'b1; start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++; if (bus1.avm_chipselect !== 1'b1 || bus1.avm_write_n !== 1'b0 || bus1.avm_address !== ea[k] || bus1.avm_writedata !== ed[k] || busy !== 1'b1) begin
                errors++; $display("FAIL start_write%0d: got cs=%b wn=%b addr=%0d data=%h busy=%b, expected 1 0 %0d %h 1", k, bus1.avm_chipselect, bus1.avm_write_n, bus1.avm_address, bus1.avm_writedata, busy, ea[k], ed[k]); end
        end
        @(negedge clk);
        checks++; if (bus1.avm_chipselect !== 1'b0 || busy !== 1'b0 || running !== 1'b1) begin
            errors++; $display("FAIL start_done: got cs=%b busy=%b run=%b, expected 0 0 1", bus1.avm_chipselect, busy, running); end
    endtask

    task automatic test_periodic_ticks;
        int b_tick, b_to, b_w, acks, n;
        $display("test_periodic_ticks: period=9 cont=1");
        b_tick = tick_seen; b_to = to_events; b_w = wlog.size();
        @(negedge clk); cfg_period = 32'd9; cfg_cont = 1'b1; start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        n = 0;
        while (tick_seen - b_tick < 5 && n < 300) begin @(negedge clk); n++; end
        checks++; if (tick_seen - b_tick != 5) begin
            errors++; $display("FAIL ticks_timeout: got %0d ticks, expected 5", tick_seen - b_tick); end
        stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
        repeat (6) @(negedge clk);
        clr_to = 1'b1; @(negedge clk); clr_to = 1'b0;
        acks = 0;
        for (int i = b_w; i < wlog.size(); i++) if (wlog[i] == {3'd0, 16'h0000}) acks++;
        checks++; if (tick_count !== 16'd5) begin
            errors++; $display("FAIL periodic_count: got %0d, expected 5", tick_count); end
        checks++; if (acks != 5) begin
            errors++; $display("FAIL periodic_acks: got %0d, expected 5", acks); end
        checks++; if (to_events - b_to != 5) begin
            errors++; $display("FAIL periodic_timeouts: got %0d, expected 5", to_events - b_to); end
        checks++; if (running !== 1'b0) begin
            errors++; $display("FAIL periodic_stop: got running=%b, expected 0", running); end
    endtask

    task automatic test_oneshot;
        int b_tick;
        $display("test_oneshot: period=4 cont=0");
        b_tick = tick_seen;
        @(negedge clk); cfg_period = 32'd4; cfg_cont = 1'b0; start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus1.avm_address !== 3'd1 || bus1.avm_writedata !== 16'h0005 || running !== 1'b1) begin
            errors++; $display("FAIL oneshot_ctl: got addr=%0d data=%h run=%b, expected 1 0005 1", bus1.avm_address, bus1.avm_writedata, running); end
        repeat (40) @(negedge clk);
        checks++; if (tick_count !== 16'd6 || tick_seen - b_tick != 1) begin
            errors++; $display("FAIL oneshot_count: got tc=%0d ticks=%0d, expected 6 1", tick_count, tick_seen - b_tick); end
        checks++; if (running !== 1'b0) begin
            errors++; $display("FAIL oneshot_running: got %b, expected 0", running); end
    endtask

    task automatic test_snapshot;
        int b_w, b_r, pulses, first;
        $display("test_snapshot: counter=00123456");
        @(negedge clk); force_cnt = 1'b1; force_val = 32'h0012_3456;
        @(negedge clk); force_cnt = 1'b0;
        b_w = wlog.size(); b_r = rlog.size();
        snap_req = 1'b1;
        @(negedge clk); snap_req = 1'b0;
        checks++; if (busy !== 1'b1 || bus1.avm_address !== 3'd4 || bus1.avm_write_n !== 1'b0) begin
            errors++; $display("FAIL snap_accept: got busy=%b addr=%0d wn=%b, expected 1 4 0", busy, bus1.avm_address, bus1.avm_write_n); end
        pulses = 0; first = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (snap_valid === 1'b1) begin pulses++; if (first < 0) first = k; end
        end
        checks++; if (pulses != 1 || first != 4) begin
            errors++; $display("FAIL snap_valid: got pulses=%0d at +%0d, expected 1 at +4", pulses, first); end
        checks++; if (snap_value !== 32'h0012_3456) begin
            errors++; $display("FAIL snap_value: got %h, expected 00123456", snap_value); end
        checks++; if (rlog.size() - b_r != 2 || rlog[b_r] !== 3'd4 || rlog[b_r+1] !== 3'd5) begin
            errors++; $display("FAIL snap_reads: got %0d reads, expected addr 4 then 5", rlog.size() - b_r); end
        checks++; if (wlog.size() - b_w != 1 || wlog[b_w] !== {3'd4, 16'h0000}) begin
            errors++; $display("FAIL snap_write: got %0d writes, expected one (4,0000)", wlog.size() - b_w); end
    endtask

    task automatic test_stop_start_irq;
        int b_w;
        logic [18:0] exp[5] = '{{3'd1, 16'h0008}, {3'd2, 16'h0000}, {3'd3, 16'h0002}, {3'd1, 16'h0007}, {3'd0, 16'h0000}};
        $display("test_stop_start_irq");
        b_w = wlog.size();
        @(negedge clk); set_to = 1'b1; stop_req = 1'b1; start_req = 1'b1; cfg_period = 32'h0002_0000; cfg_cont = 1'b1;
        @(negedge clk); set_to = 1'b0; stop_req = 1'b0; start_req = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (wlog.size() - b_w != 5) begin
            errors++; $display("FAIL order_count: got %0d writes, expected 5", wlog.size() - b_w); end
        else for (int i = 0; i < 5; i++) begin
            checks++; if (wlog[b_w+i] !== exp[i]) begin
                errors++; $display("FAIL order_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h", i, wlog[b_w+i][18:16], wlog[b_w+i][15:0], exp[i][18:16], exp[i][15:0]); end
        end
        checks++; if (tick_count !== 16'd7 || running !== 1'b1) begin
            errors++; $display("FAIL order_tick: got tc=%0d run=%b, expected 7 1", tick_count, running); end
        stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tick_wrap;
        int n;
        $display("test_tick_wrap: 17 irqs on TICK_W=4");
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); set_irq2 = 1'b1;
            @(negedge clk); set_irq2 = 1'b0;
            n = 0;
            while (irq2 && n < 10) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        checks++; if (tick_count2 !== 4'd1 || tick2_seen != 17) begin
            errors++; $display("FAIL tick_wrap: got tc=%0d ticks=%0d, expected 1 17", tick_count2, tick2_seen); end
    endtask

    task automatic test_reset_mid;
        logic [2:0]  ea[3] = '{3'd2, 3'd3, 3'd1};
        logic [15:0] ed[3] = '{16'h86A0, 16'h0001, 16'h0007};
        $display("test_reset_mid");
        @(negedge clk); cfg_period = 32'hABCD_1234; cfg_cont = 1'b1; start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        @(negedge clk);
        checks++; if (bus1.avm_address !== 3'd3 || bus1.avm_writedata !== 16'hABCD) begin
            errors++; $display("FAIL mid_wr_ph: got addr=%0d data=%h, expected 3 abcd", bus1.avm_address, bus1.avm_writedata); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus1.avm_chipselect !== 1'b0 || bus1.avm_write_n !== 1'b1 || bus1.avm_address !== 3'd0 || bus1.avm_writedata !== 16'h0) begin
            errors++; $display("FAIL mid_reset_bus: got cs=%b wn=%b addr=%0d data=%h, expected 0 1 0 0000", bus1.avm_chipselect, bus1.avm_write_n, bus1.avm_address, bus1.avm_writedata); end
        checks++; if (busy !== 1'b0 || running !== 1'b0 || tick_count !== 16'h0 || snap_value !== 32'h0 || snap_valid !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got busy=%b run=%b tc=%h snap=%h, expected all 0", busy, running, tick_count, snap_value); end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); cfg_period = 32'h0001_86A0; start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++; if (bus1.avm_chipselect !== 1'b1 || bus1.avm_write_n !== 1'b0 || bus1.avm_address !== ea[k] || bus1.avm_writedata !== ed[k]) begin
                errors++; $display("FAIL restart_write%0d: got addr=%0d data=%h, expected %0d %h", k, bus1.avm_address, bus1.avm_writedata, ea[k], ed[k]); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        @(negedge clk);
        test_start;
        test_periodic_ticks;
        test_oneshot;
        test_snapshot;
        test_stop_start_irq;
        test_tick_wrap;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
